lap_timer_8_bit: RTL and testbench
==================================

LAP_TIMER_8_BIT -- requirements
Module: lap_timer_8_bit

Interface
REQ-001 SHALL have parameter-free port list below; all registers update on rising edge of Clk_In.
REQ-002 Clk_In  input  1  system clock; upstream counter updates on the falling edge, so Count_In is sampled half a cycle after change.
REQ-003 Reset_In  input  1  reset; asynchronous, active-high.
REQ-004 Count_In  input  4  count value from upstream 4-bit MOD counter.
REQ-005 MOD_Value_In  input  4  modulus driven to the upstream counter; used live, not latched.
REQ-006 Arm_In  input  1  level; 1 = run lap timing, 0 = abort/idle.
REQ-007 Target_In  input  8  lap count at which alarm fires; latched on arm.
REQ-008 Ack_In  input  1  alarm acknowledge.
REQ-009 Lap_Count_Out  output  8  number of counter wraps since arm.
REQ-010 Wrap_Pulse_Out  output  1  one-cycle pulse per detected wrap.
REQ-011 Alarm_Out  output  1  target reached.
REQ-012 Busy_Out  output  1  high in RUN state.

Function
REQ-013 SHALL hold Prev_Count (last sampled Count_In) and Prev_Valid; Prev_Valid is cleared on reset and on IDLE->RUN, set after the first RUN sample.
REQ-014 Wrap event SHALL be: Prev_Valid=1, Prev_Count == (MOD_Value_In - 1) mod 16, Count_In == 0, MOD_Value_In != 1.
REQ-015 MOD_Value_In=0 SHALL be treated as modulus 16 (wrap 15->0); MOD_Value_In=1 SHALL never produce a wrap event.
REQ-016 Counter reset or stop mid-count (e.g. 5->0, or holding at 0) SHALL NOT be a wrap event.
REQ-017 FSM states SHALL be IDLE, RUN, ALARM; reset state IDLE.
REQ-018 IDLE->RUN SHALL occur on the edge sampling Arm_In=1; same edge clears Lap_Count_Out to 0 and latches Target_In.
REQ-019 RUN: each wrap event SHALL increment Lap_Count_Out at the sampling edge (zero latency), modulo 256.
REQ-020 RUN->ALARM SHALL occur on the same edge where the incremented lap count equals the latched target; latched target 0 means 256 (alarm when count wraps 255->0).
REQ-021 RUN->IDLE SHALL occur on Arm_In=0; Lap_Count_Out held; a wrap on that same edge is not counted.
REQ-022 ALARM: Alarm_Out=1; Lap_Count_Out frozen; wraps not counted; Arm_In ignored except as in REQ-024.
REQ-023 ALARM->IDLE SHALL occur on Ack_In=1 with Arm_In=0.
REQ-024 ALARM with Ack_In=1 and Arm_In=1 SHALL go directly to RUN with re-arm actions of REQ-018.
REQ-025 Wrap_Pulse_Out SHALL be registered, high for exactly the cycle after each counted wrap; uncounted wraps produce no pulse.
REQ-026 Busy_Out SHALL equal (state==RUN); Alarm_Out SHALL equal (state==ALARM) except per REQ-031.

Reset
REQ-027 Reset_In=1 SHALL immediately force state IDLE, Lap_Count_Out=0, Wrap_Pulse_Out=0, Alarm_Out=0, Busy_Out=0, Prev_Count=0, Prev_Valid=0, latched target=0.
REQ-028 Reset mid-RUN or mid-ALARM SHALL discard all progress; first edge after release follows REQ-018 if Arm_In=1.

Configuration
REQ-029 Macro LAP_TIMER_AUTO_RELOAD_EN SHALL select alarm behaviour.
REQ-030 Without it: alarm sticky per REQ-022 to REQ-024.
REQ-031 With it: ALARM lasts exactly one cycle (Alarm_Out one-cycle pulse), then returns to RUN with Lap_Count_Out=0, target retained, Prev_Valid kept; Ack_In ignored; Arm_In=0 during ALARM goes to IDLE.

Verification
REQ-032 MOD=10, counter free-running, Arm=1, Target=3 -> Lap_Count 1,2,3 at each 9->0 sample; Alarm_Out=1 at third; further wraps ignored.
REQ-033 Alarm held, Ack=1 Arm=0 -> IDLE next edge, Alarm_Out=0, Lap_Count_Out stays 3; Ack=1 Arm=1 -> RUN, Lap_Count_Out=0.
REQ-034 MOD=0, Target=0 -> 256 wraps (15->0) before alarm; Lap_Count_Out reads 0 at alarm.
REQ-035 Counter reset at count 5 while RUN -> no increment, no Wrap_Pulse_Out; MOD=1 running -> Lap_Count_Out stays 0.
REQ-036 Reset_In pulsed between edges at Lap_Count=2 -> all outputs 0 immediately, state IDLE.
REQ-037 With LAP_TIMER_AUTO_RELOAD_EN, Target=2 -> Alarm_Out one-cycle pulses every 2 wraps, Lap_Count_Out sequence 1,2,0,1,2,0.

Source files
------------

// File: rtl/lap_timer_8_bit.sv
// Lap timer: counts wraps of an upstream 4-bit MOD counter and raises an alarm at a latched target.
// Define LAP_TIMER_AUTO_RELOAD_EN for a one-cycle alarm pulse that restarts lap counting automatically.
module lap_timer_8_bit (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic [3:0] Count_In,
  input  logic [3:0] MOD_Value_In,
  input  logic       Arm_In,
  input  logic [7:0] Target_In,
  input  logic       Ack_In,
  output logic [7:0] Lap_Count_Out,
  output logic       Wrap_Pulse_Out,
  output logic       Alarm_Out,
  output logic       Busy_Out
);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

  state_t     state, state_next;
  logic [7:0] lap_count, lap_count_next;
  logic [7:0] target, target_next;
  logic [7:0] lap_inc;
  logic [3:0] prev_count;
  logic [3:0] wrap_from;
  logic       prev_valid, prev_valid_next;
  logic       wrap_pulse, wrap_pulse_next;
  logic       wrap_event;

  // A zero modulus value stands for 16, so the 4-bit subtract wrapping 0 -> 15 is intended.
  assign wrap_from  = MOD_Value_In - 4'd1;
  assign wrap_event = prev_valid && (prev_count == wrap_from) &&
                      (Count_In == 4'd0) && (MOD_Value_In != 4'd1);
  // Target 0 stands for 256: the 8-bit increment rolls 255 -> 0 and matches it.
  assign lap_inc    = lap_count + 8'd1;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next      = state;
    lap_count_next  = lap_count;
    target_next     = target;
    prev_valid_next = prev_valid;
    wrap_pulse_next = 1'b0;
    case (state)
      IDLE: begin
        if (Arm_In) begin
          state_next      = RUN;
          lap_count_next  = 8'd0;
          target_next     = Target_In;
          prev_valid_next = 1'b0;
        end
      end
      RUN: begin
        prev_valid_next = 1'b1;
        if (!Arm_In) begin
          state_next = IDLE;
        end else if (wrap_event) begin
          lap_count_next  = lap_inc;
          wrap_pulse_next = 1'b1;
          if (lap_inc == target) state_next = ALARM;
        end
      end
      ALARM: begin
`ifdef LAP_TIMER_AUTO_RELOAD_EN
        if (!Arm_In) begin
          state_next = IDLE;
        end else begin
          state_next     = RUN;
          lap_count_next = 8'd0;
        end
`else
        if (Ack_In) begin
          if (Arm_In) begin
            state_next      = RUN;
            lap_count_next  = 8'd0;
            target_next     = Target_In;
            prev_valid_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      lap_count  <= 8'd0;
      target     <= 8'd0;
      prev_count <= 4'd0;
      prev_valid <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      lap_count  <= lap_count_next;
      target     <= target_next;
      prev_count <= Count_In;
      prev_valid <= prev_valid_next;
      wrap_pulse <= wrap_pulse_next;
    end
  end

  assign Lap_Count_Out  = lap_count;
  assign Wrap_Pulse_Out = wrap_pulse;
  assign Alarm_Out      = (state == ALARM);
  assign Busy_Out       = (state == RUN);

endmodule

// File: tb/tb_lap_timer_8_bit.sv
// Scoreboard bench for lap_timer_8_bit: a lap-counting reference model queues expected outputs per edge,
// and a monitor compares them after each rising edge. Honors LAP_TIMER_AUTO_RELOAD_EN like the design.
module tb_lap_timer_8_bit;

  logic       Clk_In = 1'b0;
  logic       Reset_In;
  logic [3:0] Count_In;
  logic [3:0] MOD_Value_In;
  logic       Arm_In;
  logic [7:0] Target_In;
  logic       Ack_In;
  logic [7:0] Lap_Count_Out;
  logic       Wrap_Pulse_Out;
  logic       Alarm_Out;
  logic       Busy_Out;

  lap_timer_8_bit dut (
    .Clk_In        (Clk_In),
    .Reset_In      (Reset_In),
    .Count_In      (Count_In),
    .MOD_Value_In  (MOD_Value_In),
    .Arm_In        (Arm_In),
    .Target_In     (Target_In),
    .Ack_In        (Ack_In),
    .Lap_Count_Out (Lap_Count_Out),
    .Wrap_Pulse_Out(Wrap_Pulse_Out),
    .Alarm_Out     (Alarm_Out),
    .Busy_Out      (Busy_Out)
  );

  always #5 Clk_In = ~Clk_In;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  // Reference model: laps since arm as a plain integer, effective target 1..256.
  bit m_running, m_alarmed, m_prev_ok;
  int m_laps, m_target, m_prev;
  int cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_alarmed = 0; m_prev_ok = 0;
    m_laps = 0; m_target = 256; m_prev = 0;
  endtask

  task automatic model_arm();
    m_running = 1; m_alarmed = 0; m_laps = 0; m_prev_ok = 0;
    m_target  = (Target_In == 0) ? 256 : int'(Target_In);
  endtask

  task automatic model_edge();
    int m;
    bit wrap, pulse;
    logic [7:0] lap8;
    m     = (MOD_Value_In == 0) ? 16 : int'(MOD_Value_In);
    wrap  = m_prev_ok && (Count_In == 0) && (MOD_Value_In != 1) && (m_prev == m - 1);
    pulse = 0;
    if (m_alarmed) begin
`ifdef LAP_TIMER_AUTO_RELOAD_EN
      m_alarmed = 0;
      if (Arm_In) begin
        m_running = 1;
        m_laps    = 0;
      end
`else
      if (Ack_In) begin
        if (Arm_In) model_arm();
        else m_alarmed = 0;
      end
`endif
    end else if (m_running) begin
      if (!Arm_In) begin
        m_running = 0;
      end else if (wrap) begin
        m_laps++;
        pulse = 1;
        if (m_laps == m_target) begin
          m_running = 0;
          m_alarmed = 1;
        end
      end
      if (m_running || m_alarmed) m_prev_ok = 1;
    end else if (Arm_In) begin
      model_arm();
    end
    m_prev = int'(Count_In);
    lap8   = 8'(m_laps % 256);
    exp_q.push_back({lap8, pulse, m_alarmed, m_running});
  endtask

  // Called at a falling edge: advance the upstream counter, predict the next rising edge, wait a cycle.
  task automatic step(input bit hold = 0, input bit zap = 0);
    int m;
    m = (MOD_Value_In == 0) ? 16 : int'(MOD_Value_In);
    if (zap) cnt = 0;
    else if (!hold) cnt = (cnt + 1) % m;
    Count_In = 4'(cnt);
    model_edge();
    @(negedge Clk_In);
  endtask

  task automatic reset_pulse();
    #1 Reset_In = 1'b1;
    #1 check("async_reset", {Lap_Count_Out, Wrap_Pulse_Out, Alarm_Out, Busy_Out}, 32'd0);
    #1 Reset_In = 1'b0;
    model_reset();
  endtask

  initial begin
    forever begin
      @(posedge Clk_In);
      #1;
      if (exp_q.size() > 0)
        check("outputs", {Lap_Count_Out, Wrap_Pulse_Out, Alarm_Out, Busy_Out}, {21'd0, exp_q.pop_front()});
    end
  end

  initial begin
    Reset_In = 1'b1; Count_In = 4'd0; MOD_Value_In = 4'd10;
    Arm_In = 1'b0; Target_In = 8'd0; Ack_In = 1'b0; cnt = 0;
    model_reset();
    #3 check("reset_state", {Lap_Count_Out, Wrap_Pulse_Out, Alarm_Out, Busy_Out}, 32'd0);
    repeat (2) @(negedge Clk_In);
    Reset_In = 1'b0;

    // Ten-state counter, target 3, free-running, then acknowledge and re-arm.
    Target_In = 8'd3; Arm_In = 1'b1;
    repeat (40) step();
    Ack_In = 1'b1; Arm_In = 1'b0; step();
    Ack_In = 1'b0; repeat (3) step();
    Arm_In = 1'b1; repeat (40) step();
    Ack_In = 1'b1; step();
    Ack_In = 1'b0; repeat (10) step();

    // Sixteen-state counter with target 0 (256 laps).
    Arm_In = 1'b0; step();
    MOD_Value_In = 4'd0; Target_In = 8'd0; Arm_In = 1'b1;
    repeat (256 * 16 + 40) step();

    // Counter reset mid-count and held at zero, then modulus 1.
    Arm_In = 1'b0; step();
    MOD_Value_In = 4'd10; Target_In = 8'd50; Arm_In = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 20 && cnt != 5; i++) step();
    repeat (4) step(0, 1);
    repeat (20) step();
    Arm_In = 1'b0; step();
    MOD_Value_In = 4'd1; Arm_In = 1'b1;
    repeat (20) step();

    // Asynchronous reset between edges at lap 2, then re-arm on release.
    Arm_In = 1'b0; step();
    MOD_Value_In = 4'd10; Target_In = 8'd9; Arm_In = 1'b1;
    for (int i = 0; i < 100 && m_laps != 2; i++) step();
    reset_pulse();
    repeat (30) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) MOD_Value_In = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) Arm_In = ~Arm_In;
      Ack_In    = ($urandom_range(0, 7) == 0);
      Target_In = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) reset_pulse();
      case ($urandom_range(0, 19))
        0:       step(1, 0);
        1:       step(0, 1);
        default: step();
      endcase
    end

    repeat (3) @(negedge Clk_In);
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
